ql_membank_programmer: RTL and testbench
========================================

QL_MEMBANK_PROGRAMMER -- requirements
Module: ql_membank_programmer

Interface
REQ-001 SHALL have parameter BL_NUM, default 8, meaning bit-line count (word width per row).
REQ-002 SHALL have parameter WL_NUM, default 8, meaning word-line count (rows).
REQ-003 SHALL have parameter SETUP_CYC, default 1, meaning cycles bl is stable before wl rises; minimum 1.
REQ-004 SHALL have parameter PULSE_CYC, default 2, meaning cycles wl is high; minimum 1.
REQ-005 SHALL have parameter HOLD_CYC, default 1, meaning cycles bl is held after wl falls; minimum 1.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows.
REQ-007 SHALL have port prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-008 SHALL have port global_resetn  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  begin programming of all WL_NUM rows.
REQ-010 SHALL have port abort  input  1  synchronous abort of the current sequence.
REQ-011 SHALL have port din  input  BL_NUM  row data word.
REQ-012 SHALL have port din_valid  input  1  din holds a valid word.
REQ-013 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-014 SHALL have port bl  output  [0:BL_NUM-1]  bit-line drive.
REQ-015 SHALL have port wl  output  [0:WL_NUM-1]  word-line drive, one-hot or zero.
REQ-016 SHALL have port busy  output  1  sequence in progress (any state other than IDLE).
REQ-017 SHALL have port done  output  1  one-cycle pulse after the last row completes.

Function
REQ-018 SHALL implement the states IDLE, FETCH, SETUP, PULSE, HOLD and DONE.
REQ-019 SHALL register all outputs.
REQ-020 IDLE: start=1 -> FETCH with row=0; start SHALL be ignored in every other state.
REQ-021 FETCH: din_ready=1, bl held at the previous value; a transfer occurs when din_valid&din_ready; on transfer, din is captured into bl and the state becomes SETUP; wait indefinitely otherwise.
REQ-022 SHALL assert din_ready only in FETCH.
REQ-023 SETUP: wl=0 for SETUP_CYC cycles -> PULSE.
REQ-024 PULSE: wl[row]=1 and all other wl bits 0 for exactly PULSE_CYC cycles -> HOLD.
REQ-025 HOLD: wl=0 and bl unchanged for HOLD_CYC cycles; then DONE if row==WL_NUM-1, else row+1 and FETCH.
REQ-026 DONE: done=1 for one cycle, bl cleared to 0, then IDLE.
REQ-027 Minimum per-row latency SHALL be 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles from FETCH entry.
REQ-028 bl SHALL never change while any wl bit is 1.
REQ-029 Row and cycle counters SHALL be $clog2-sized; row SHALL never wrap past WL_NUM-1.
REQ-030 abort=1 in any non-IDLE state -> next cycle IDLE with wl=0, bl=0, done=0; abort SHALL take priority over all transitions.
REQ-031 A din_valid word presented on the same cycle as abort SHALL not be consumed.

Reset
REQ-032 global_resetn=0 SHALL asynchronously force IDLE with row=0, bl=0, wl=0, din_ready=0, busy=0, done=0 (and rb_err=0 when present).
REQ-033 Reset deassertion in the middle of a sequence SHALL resume from IDLE only; no partial row is continued.

Configuration
REQ-034 With macro PROG_READBACK_EN defined, SHALL add ports rb_data (input, BL_NUM) and rb_err (output, 1).
REQ-035 With PROG_READBACK_EN defined, rb_data SHALL be sampled on the first HOLD cycle of each row and compared with bl; any mismatch SHALL set rb_err, which is sticky until the next accepted start or reset.
REQ-036 Without PROG_READBACK_EN, the rb_data and rb_err ports and the compare logic SHALL be absent.

Structure
REQ-037 Package ql_prog_pkg SHALL hold the state enum and the default timing constants.
REQ-038 SHALL have sub-module ql_prog_wl_decoder: row index plus enable -> one-hot wl vector.

Verification
REQ-039 BL_NUM=4, WL_NUM=3, defaults, din 0xA,0x5,0xF with din_valid held high -> wl[0], wl[1], wl[2] each high for 2 cycles with bl=0xA, 0x5, 0xF respectively; done pulses once; 5 cycles per row.
REQ-040 din_valid withheld for 4 cycles in FETCH of row 1 -> din_ready stays 1, wl stays 0, the sequence resumes on the valid cycle.
REQ-041 abort asserted during PULSE of row 1 -> next cycle wl=0, bl=0, busy=0, no done pulse.
REQ-042 start pulsed while busy -> no effect; row count and timing unchanged.
REQ-043 global_resetn dropped mid-PULSE -> wl=0 immediately, without waiting for a clock edge; after release, a new start programs from row 0.
REQ-044 PROG_READBACK_EN defined, rb_data differs from bl on row 2 -> rb_err=1 and stays 1 through done; the next start clears it.

Source files
------------

// File: rtl/ql_prog_pkg.sv
// Shared types and default timing for the memory-bank programmer.
// State enum, default geometry/timing constants and width helpers.
package ql_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } prog_state_e;

    localparam int DEF_BL_NUM    = 8;
    localparam int DEF_WL_NUM    = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ql_prog_wl_decoder.sv
// Row index plus enable to a one-hot (or all-zero) word-line vector.
module ql_prog_wl_decoder #(
    parameter int WL_NUM = 8,
    parameter int ROW_W  = 3
) (
    input  logic [ROW_W-1:0] row_i,
    input  logic             en_i,
    output logic [0:WL_NUM-1] wl_o
);

    for (genvar g = 0; g < WL_NUM; g++) begin : g_wl
        assign wl_o[g] = en_i && (row_i == ROW_W'(g));
    end

endmodule

// File: rtl/ql_membank_programmer.sv
// Row-by-row bit-line/word-line programming sequencer with registered outputs.
// Optional readback compare is enabled by defining PROG_READBACK_EN.
module ql_membank_programmer
    import ql_prog_pkg::*;
#(
    parameter int BL_NUM    = DEF_BL_NUM,
    parameter int WL_NUM    = DEF_WL_NUM,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              prog_clk,
    input  logic              global_resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [BL_NUM-1:0] din,
`ifdef PROG_READBACK_EN
    input  logic [BL_NUM-1:0] rb_data,
    output logic              rb_err,
`endif
    input  logic              din_valid,
    output logic              din_ready,
    output logic [0:BL_NUM-1] bl,
    output logic [0:WL_NUM-1] wl,
    output logic              busy,
    output logic              done
);

    localparam int ROW_W = idx_w(WL_NUM);
    localparam int CNT_W = idx_w(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC));

    prog_state_e       state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:BL_NUM-1] bl_q, bl_d;
    logic [0:WL_NUM-1] wl_q, wl_d;
    logic              din_ready_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        bl_d    = bl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                end
            end
            // din_ready is high in every FETCH cycle, so din_valid alone is the handshake.
            ST_FETCH: begin
                if (din_valid) begin
                    state_d = ST_SETUP;
                    bl_d    = din;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    cnt_d = '0;
                    if (row_q == ROW_W'(WL_NUM - 1)) begin
                        state_d = ST_DONE;
                        bl_d    = '0;
                    end else begin
                        state_d = ST_FETCH;
                        row_d   = row_q + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            row_d   = '0;
            cnt_d   = '0;
            bl_d    = '0;
        end
    end

    // Word lines are decoded from next-state so they register alongside bl.
    ql_prog_wl_decoder #(
        .WL_NUM(WL_NUM),
        .ROW_W (ROW_W)
    ) u_wl_dec (
        .row_i(row_d),
        .en_i (state_d == ST_PULSE),
        .wl_o (wl_d)
    );

    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            bl_q        <= bl_d;
            wl_q        <= wl_d;
            din_ready_q <= (state_d == ST_FETCH);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign din_ready = din_ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef PROG_READBACK_EN
    logic rb_err_q, rb_err_d;

    // Sticky mismatch flag, sampled on the first HOLD cycle of each row.
    always_comb begin
        rb_err_d = rb_err_q;
        if ((state_q == ST_IDLE) && start) begin
            rb_err_d = 1'b0;
        end else if ((state_q == ST_HOLD) && (cnt_q == '0) && (rb_data != bl_q)) begin
            rb_err_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) rb_err_q <= 1'b0;
        else                rb_err_q <= rb_err_d;
    end

    assign rb_err = rb_err_q;
`endif

endmodule

// File: tb/tb_ql_membank_programmer.sv
// Randomised and directed bench for ql_membank_programmer against a timeline model.
module tb_ql_membank_programmer;

    localparam int BLN = 4;
    localparam int WLN = 3;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           din_valid = 1'b0;
    logic [BLN-1:0] din;
    logic           din_ready, busy, done;
    logic [0:BLN-1] bl;
    logic [0:WLN-1] wl;
`ifdef PROG_READBACK_EN
    logic [BLN-1:0] rb_data;
    logic           rb_err;
    bit             rb_inj = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [BLN-1:0] feed_mem [0:2];
    int feed_idx = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wl_cnt [3] = '{0, 0, 0};
    int wl_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign din = feed_mem[(feed_idx > 2) ? 2 : feed_idx];
`ifdef PROG_READBACK_EN
    assign rb_data = bl ^ ((rb_inj && feed_idx == 3) ? 4'h1 : 4'h0);
`endif

    ql_membank_programmer #(
        .BL_NUM(BLN), .WL_NUM(WLN), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .prog_clk(clk), .global_resetn(rstn), .start(start), .abort(abort),
        .din(din),
`ifdef PROG_READBACK_EN
        .rb_data(rb_data), .rb_err(rb_err),
`endif
        .din_valid(din_valid), .din_ready(din_ready), .bl(bl), .wl(wl),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Feed pointer and cycle bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) feed_idx <= 0;
        else if (start && !busy) begin
            feed_idx  <= 0;
            start_cyc <= cyc + 1;
        end else if (din_valid && din_ready && !abort) feed_idx <= feed_idx + 1;
    end

    // Timeline model: t counts cycles since a row's word was accepted.
    bit m_busy, m_fetch, m_done, m_rb;
    int m_row, m_t;
    logic [BLN-1:0] m_bl;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 0; m_fetch <= 0; m_done <= 0; m_rb <= 0;
            m_row <= 0; m_t <= 0; m_bl <= '0;
        end else begin
`ifdef PROG_READBACK_EN
            if (!m_busy && start) m_rb <= 0;
            else if (m_busy && !m_fetch && !m_done && m_t == S + P && rb_data != m_bl) m_rb <= 1;
`endif
            if (m_done) begin
                m_done <= 0; m_busy <= 0;
            end else if (!m_busy) begin
                if (start) begin m_busy <= 1; m_fetch <= 1; m_row <= 0; end
            end else if (abort) begin
                m_busy <= 0; m_fetch <= 0; m_bl <= '0; m_row <= 0;
            end else if (m_fetch) begin
                if (din_valid) begin m_fetch <= 0; m_t <= 0; m_bl <= din; end
            end else if (m_t + 1 == S + P + H) begin
                if (m_row == WLN - 1) begin m_done <= 1; m_bl <= '0; end
                else begin m_row <= m_row + 1; m_fetch <= 1; end
            end else m_t <= m_t + 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [0:WLN-1] e_wl;
        if (rstn) begin
            e_wl = '0;
            if (m_busy && !m_fetch && !m_done && m_t >= S && m_t < S + P) e_wl[m_row] = 1'b1;
            check("bl", bl, m_bl);
            check("wl", wl, e_wl);
            check("busy", busy, m_busy);
            check("din_ready", din_ready, m_busy && m_fetch);
            check("done", done, m_done);
`ifdef PROG_READBACK_EN
            check("rb_err", rb_err, m_rb);
`endif
        end
    end

    // Word-line and done statistics for the directed literal checks.
    always @(negedge clk) begin
        if (rstn) begin
            for (int r = 0; r < WLN; r++) begin
                if (wl[r]) begin
                    wl_cnt[r]++;
                    if (bl != feed_mem[r]) wl_bad++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_seq(input bit noise, input bit withhold, input int exp_lat);
        int c0 [3];
        int b0, d0, lat;
        bit ok, held;
        feed_mem[0] = 4'hA; feed_mem[1] = 4'h5; feed_mem[2] = 4'hF;
        c0 = wl_cnt; b0 = wl_bad; d0 = done_cnt;
        ok = 0; held = 0; lat = 0;
        din_valid = 1; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (withhold && !held && din_ready && feed_idx == 1) begin
                held = 1; din_valid = 0;
                repeat (4) begin
                    @(negedge clk);
                    check("hold_ready", din_ready, 1);
                    check("hold_wl", wl, 0);
                end
                din_valid = 1;
            end
            if (noise) start = (i % 3 == 1);
            @(negedge clk);
            if (done) begin ok = 1; lat = cyc - start_cyc; end
        end
        start = 0;
        check("done_seen", ok, 1);
        check("done_lat", lat, exp_lat);
`ifdef PROG_READBACK_EN
        if (rb_inj) check("rb_err_at_done", rb_err, 1);
`endif
        repeat (2) @(negedge clk);
        for (int r = 0; r < WLN; r++) check("wl_pulse_len", wl_cnt[r] - c0[r], 2);
        check("bl_during_wl", wl_bad - b0, 0);
        check("done_once", done_cnt - d0, 1);
        check("idle_after", busy, 0);
    endtask

    task automatic wait_wl(input int r);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wl[r]) ok = 1;
        end
        check("wl_reached", ok, 1);
    endtask

    task automatic drain();
        bit ok;
        abort = 0; start = 0; din_valid = 1; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        check("drain_idle", ok, 1);
    endtask

    initial begin
        int d0;
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        feed_mem[0] = '0; feed_mem[1] = '0; feed_mem[2] = '0;
        #2;
        check("rst_bl", bl, 0);
        check("rst_wl", wl, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", din_ready, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rstn = 1;
        repeat (2) @(negedge clk);

        // Back-to-back rows, then stall on row 1, then start noise while busy.
        run_seq(0, 0, 15);
        run_seq(0, 1, 19);
        run_seq(1, 0, 15);

        // Abort during row 1 pulse.
        feed_mem[0] = 4'h3; feed_mem[1] = 4'hC; feed_mem[2] = 4'h9;
        din_valid = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_wl(1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_wl", wl, 0);
        check("abort_bl", bl, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // Abort together with a valid word: the word is not taken.
        din_valid = 0; start = 1;
        @(negedge clk);
        start = 0;
        check("fetch_ready", din_ready, 1);
        din_valid = 1; abort = 1;
        @(negedge clk);
        abort = 0; din_valid = 0;
        check("abort_fetch_bl", bl, 0);
        check("abort_fetch_busy", busy, 0);
        check("abort_fetch_idx", feed_idx, 0);

        // Asynchronous reset during a pulse.
        din_valid = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_wl(0);
        #2 rstn = 0;
        #1;
        check("arst_wl", wl, 0);
        check("arst_busy", busy, 0);
        check("arst_bl", bl, 0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        run_seq(0, 0, 15);

`ifdef PROG_READBACK_EN
        rb_inj = 1;
        run_seq(0, 0, 15);
        check("rb_err_sticky", rb_err, 1);
        rb_inj = 0;
        din_valid = 1; start = 1;
        @(negedge clk);
        start = 0;
        check("rb_err_cleared", rb_err, 0);
        drain();
`endif

        // Randomised sequences with stalls, stray starts and occasional aborts.
        for (int s = 0; s < 30; s++) begin
            for (int k = 0; k < 3; k++) feed_mem[k] = BLN'($urandom);
            start = 1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                start = ($urandom % 8 == 0);
                din_valid = ($urandom % 3 != 0);
                abort = ($urandom % 60 == 0);
            end
            drain();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
